// File: rtl/sisc_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sisc_mem_arb                                                  |
// | Description : Shares one single-port SISC memory between the instruction-   |
// |               fetch port (read only) and the data port (LOD/STR). Grants    |
// |               one requester, issues one access, waits MEM_LAT cycles and    |
// |               returns read data or a write acknowledge to the winner.       |
// |               States: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.        |
// | Ports       : clk, rst_f (async, active-low)                                |
// |               fetch : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out      |
// |               data  : d_req/d_we/d_addr/d_wdata in,                         |
// |                       d_gnt/d_rvalid/d_rdata out                            |
// |               memory: mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in    |
// |               busy  : high whenever the sequencer is not IDLE               |
// | Options     : SISC_MEM_ARB_RR_EN - round-robin on simultaneous requests     |
// |               (default: data port always beats fetch port)                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sisc_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1     // 1..15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Counter preload: WAIT lasts exactly MEM_LAT cycles, so the capture
  // lands on cycle ISSUE+MEM_LAT.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t          state_q,     state_d;
  logic [3:0]      cnt_q,       cnt_d;
  logic            win_data_q,  win_data_d;   // 1 = data port owns the access
  logic            we_q,        we_d;
  logic [AW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   wdata_q,     wdata_d;
  logic            if_gnt_q,    if_gnt_d;
  logic            d_gnt_q,     d_gnt_d;
  logic            mem_en_q,    mem_en_d;
  logic            mem_we_q,    mem_we_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q,  d_rvalid_d;
  logic [DW-1:0]   if_rdata_q,  if_rdata_d;
  logic [DW-1:0]   d_rdata_q,   d_rdata_d;
  logic            busy_q,      busy_d;
  logic            data_wins;

`ifdef SISC_MEM_ARB_RR_EN
  logic            last_winner_q, last_winner_d;  // 1 = data won last grant
  // On a tie the port that did not win last time goes first.
  assign data_wins = d_req & (~if_req | ~last_winner_q);
`else
  assign data_wins = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_data_d  = win_data_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = '0;
    d_rdata_d   = '0;
`ifdef SISC_MEM_ARB_RR_EN
    last_winner_d = last_winner_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          // Latch the winner's request; gnt/mem_* are registered so they
          // appear during the ISSUE cycle.
          win_data_d = data_wins;
          we_d       = data_wins & d_we;
          addr_d     = data_wins ? d_addr : if_addr;
          wdata_d    = (data_wins && d_we) ? d_wdata : '0;
          if_gnt_d   = ~data_wins;
          d_gnt_d    = data_wins;
          mem_en_d   = 1'b1;
          mem_we_d   = data_wins & d_we;
          state_d    = ST_ISSUE;
`ifdef SISC_MEM_ARB_RR_EN
          last_winner_d = data_wins;
`endif
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Capture straight into the response registers so rvalid/rdata
          // are presented during RESP.
          if_rvalid_d = ~win_data_q;
          d_rvalid_d  = win_data_q;
          if_rdata_d  = win_data_q ? '0 : mem_rdata;
          d_rdata_d   = (win_data_q && !we_q) ? mem_rdata : '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin  // ST_RESP
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_data_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
`ifdef SISC_MEM_ARB_RR_EN
      last_winner_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_data_q  <= win_data_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef SISC_MEM_ARB_RR_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
